// File: rtl/column_alu_pkg.sv
// column_alu_pkg
//   Shared definitions for the column ALU: opcode and FSM state enums,
//   the reduction-opcode helper and the signed extremes of the default
//   32-bit datapath.
//   Optional feature macro used by the design files: ALU_SAT_EN.
package column_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_MIN  = 4'd3,
        OP_MAX  = 4'd4,
        OP_RSUM = 4'd8,
        OP_RMIN = 4'd9,
        OP_RMAX = 4'd10,
        OP_RCNT = 4'd11
    } op_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } state_e;

    localparam int unsigned ALU_DATA_W = 32;
    localparam logic signed [ALU_DATA_W-1:0] ALU_SMAX = 32'sh7FFF_FFFF;
    localparam logic signed [ALU_DATA_W-1:0] ALU_SMIN = 32'sh8000_0000;

    // True for the defined reduction opcodes (MSB set, RSUM..RCNT).
    function automatic logic is_reduction(input logic [3:0] cmd);
        return cmd[3] && (cmd[2:0] <= 3'd3);
    endfunction

    function automatic logic is_known_op(input logic [3:0] cmd);
        case (cmd)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
            4'd8, 4'd9, 4'd10, 4'd11: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/column_alu_arith.sv
// column_alu_arith
//   Combinational operation unit shared by the elementwise and reduction
//   paths of column_alu. Computes ADD/SUB/MUL (low DATA_W bits) with signed
//   overflow detection, and signed MIN/MAX. Reduction opcodes map onto the
//   matching elementwise operation (RSUM->ADD, RMIN->MIN, RMAX->MAX).
//   With macro ALU_SAT_EN defined, overflowing ADD/SUB/MUL/RSUM results
//   clamp to the signed extremes; otherwise they wrap.
// Ports:
//   a, b    signed operands
//   op      opcode (op_e)
//   result  signed result
//   ovf     exact result not representable in DATA_W bits
module column_alu_arith
    import column_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  op_e                      op,
    output logic signed [DATA_W-1:0] result,
    output logic                     ovf
);

`ifdef ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Picks the clamp or the wrapped value; neg is the sign of the exact result.
    function automatic logic signed [DATA_W-1:0] fix_result(
        input logic                     o,
        input logic                     neg,
        input logic signed [DATA_W-1:0] wrapped
    );
        logic signed [DATA_W-1:0] clamp;
        clamp = neg ? SMIN : SMAX;
        return (SAT_EN && o) ? clamp : wrapped;
    endfunction

    logic signed [DATA_W:0]     sum;
    logic signed [DATA_W:0]     dif;
    logic signed [2*DATA_W-1:0] prod;

    always_comb begin
        // One guard bit is enough to see add/sub overflow; the product is
        // formed at full width from sign-extended operands.
        sum    = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        dif    = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        prod   = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD, OP_RSUM: begin
                ovf    = sum[DATA_W] ^ sum[DATA_W-1];
                result = fix_result(ovf, sum[DATA_W], sum[DATA_W-1:0]);
            end
            OP_SUB: begin
                ovf    = dif[DATA_W] ^ dif[DATA_W-1];
                result = fix_result(ovf, dif[DATA_W], dif[DATA_W-1:0]);
            end
            OP_MUL: begin
                // Representable only if the upper half is a sign extension.
                ovf    = !((&prod[2*DATA_W-1:DATA_W-1]) || !(|prod[2*DATA_W-1:DATA_W-1]));
                result = fix_result(ovf, prod[2*DATA_W-1], prod[DATA_W-1:0]);
            end
            OP_MIN, OP_RMIN: result = (a < b) ? a : b;
            OP_MAX, OP_RMAX: result = (a > b) ? a : b;
            default:         result = '0;
        endcase
    end

endmodule

// File: rtl/column_alu.sv
// column_alu
//   Streaming two-operand ALU for column operations. Elementwise opcodes
//   produce one result per accepted beat; reduction opcodes accumulate in1
//   over a frame closed by in_last and produce one result per frame.
//   Valid/ready on both sides with a single registered output stage.
//   Optional macro ALU_SAT_EN: saturating ADD/SUB/MUL/RSUM (RSUM stays
//   clamped for the rest of the frame once it saturates).
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid / in_ready   input handshake
//   in1, in2, cmd, in_last  operands, opcode, end-of-frame marker
//   out_valid / out_ready output handshake
//   out, out_last, ovf    result, frame-closing flag, overflow flag
//   err                   sticky error (unknown opcode or mid-frame cmd change)
module column_alu
    import column_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in1,
    input  logic signed [DATA_W-1:0] in2,
    input  logic [CMD_W-1:0]         cmd,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out,
    output logic                     out_last,
    output logic                     ovf,
    output logic                     err
);

`ifdef ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_e                   state_q;
    logic [CMD_W-1:0]         cmd_q;
    logic signed [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     sum_ovf_q;
    logic signed [DATA_W-1:0] out_q;
    logic                     out_valid_q;
    logic                     out_last_q;
    logic                     ovf_q;
    logic                     err_q;

    logic                     accept;
    logic                     emit;
    logic                     err_set;
    logic [CMD_W-1:0]         eff_cmd;
    logic [3:0]               op_lo;
    logic                     op_known;
    logic                     op_red;
    op_e                      op;
    logic                     first;
    logic signed [DATA_W-1:0] ar_a;
    logic signed [DATA_W-1:0] ar_b;
    logic signed [DATA_W-1:0] ar_res;
    logic                     ar_ovf;
    logic signed [DATA_W-1:0] acc_d;
    logic [CNT_W-1:0]         cnt_d;
    logic                     sum_ovf_d;
    logic signed [DATA_W-1:0] res_d;
    logic                     ovf_d;
    logic                     last_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // Inside a frame the opcode latched on its first beat governs.
        eff_cmd  = (state_q == S_FRAME) ? cmd_q : cmd;
        op_lo    = eff_cmd[3:0];
        op_known = ((eff_cmd >> 4) == '0) && is_known_op(op_lo);
        op_red   = op_known && is_reduction(op_lo);
        op       = op_e'(op_lo);
        first    = (cnt_q == '0);

        // The first reduction beat seeds the accumulator with in1 itself:
        // 0+in1 for RSUM, min/max(in1,in1) for RMIN/RMAX.
        if (op_red) begin
            ar_b = in1;
            if (first) ar_a = (op == OP_RSUM) ? '0 : in1;
            else       ar_a = acc_q;
        end else begin
            ar_a = in1;
            ar_b = in2;
        end

        cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        sum_ovf_d = sum_ovf_q || ((op == OP_RSUM) && ar_ovf);
        // A saturated running sum is held until the frame closes.
        acc_d     = (SAT_EN && (op == OP_RSUM) && sum_ovf_q) ? acc_q : ar_res;

        if (!op_known) begin
            res_d  = '0;
            ovf_d  = 1'b0;
            last_d = in_last;
        end else if (op_red) begin
            res_d  = (op == OP_RCNT) ? DATA_W'(cnt_d) : acc_d;
            ovf_d  = (op == OP_RSUM) && sum_ovf_d;
            last_d = 1'b1;
        end else begin
            res_d  = ar_res;
            ovf_d  = ar_ovf;
            last_d = in_last;
        end

        emit    = accept && (!op_red || in_last);
        err_set = accept && (!op_known || ((state_q == S_FRAME) && (cmd != cmd_q)));
    end

    column_alu_arith #(
        .DATA_W (DATA_W)
    ) u_arith (
        .a      (ar_a),
        .b      (ar_b),
        .op     (op),
        .result (ar_res),
        .ovf    (ar_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_ovf_q   <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Output stage: a new result overwrites a consumed one with no bubble.
            if (emit) begin
                out_valid_q <= 1'b1;
                out_q       <= res_d;
                out_last_q  <= last_d;
                ovf_q       <= ovf_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (err_set) err_q <= 1'b1;

            if (accept) begin
                case (state_q)
                    S_IDLE: begin
                        if (!in_last) begin
                            state_q <= S_FRAME;
                            cmd_q   <= cmd;
                        end
                    end
                    S_FRAME: begin
                        if (in_last) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase

                if (op_red) begin
                    if (in_last) begin
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        sum_ovf_q <= 1'b0;
                    end else begin
                        acc_q     <= acc_d;
                        cnt_q     <= cnt_d;
                        sum_ovf_q <= sum_ovf_d;
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_last  = out_last_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_column_alu.sv
// Self-checking bench for column_alu: directed beats, expected results
// queued at issue time and compared by an output monitor.
module tb_column_alu;
    import column_alu_pkg::*;

    localparam int W = 32;

`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in1;
    logic signed [W-1:0] in2;
    logic [3:0]          cmd;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out;
    logic                out_last;
    logic                ovf;
    logic                err;

    always #5 clk = ~clk;

    column_alu #(
        .DATA_W (W),
        .CMD_W  (4),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cmd       (cmd),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_last  (out_last),
        .ovf       (ovf),
        .err       (err)
    );

    typedef struct packed {
        logic signed [W-1:0] data;
        logic                last;
        logic                ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic push(input logic signed [W-1:0] d, input logic l, input logic o);
        exp_t e;
        e.data = d;
        e.last = l;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                        input logic [3:0] c, input logic l);
        int n;
        n        = 0;
        in1      = a;
        in2      = b;
        cmd      = c;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_accept", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got out=%0d with no result pending", out);
            end else begin
                mon_e = sb.pop_front();
                check("sb_data", out, mon_e.data);
                check("sb_last", out_last, mon_e.last);
                check("sb_ovf", ovf, mon_e.ovf);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        cmd       = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);

        // ADD stream, one result per cycle with latency 1
        push(12, 1'b0, 1'b0);
        push(-1, 1'b0, 1'b0);
        push(SAT ? ALU_SMAX : ALU_SMIN, 1'b1, 1'b1);
        send(5, 7, OP_ADD, 1'b0);
        check("add_latency0", out_valid, 1'b1);
        send(-3, 2, OP_ADD, 1'b0);
        check("add_latency1", out_valid, 1'b1);
        send(ALU_SMAX, 1, OP_ADD, 1'b1);
        check("add_latency2", out_valid, 1'b1);

        // Other elementwise ops
        push(-7, 1'b1, 1'b0);
        send(3, 10, OP_SUB, 1'b1);
        push(SAT ? ALU_SMIN : ALU_SMAX, 1'b1, 1'b1);
        send(ALU_SMIN, 1, OP_SUB, 1'b1);
        push(-24, 1'b1, 1'b0);
        send(-4, 6, OP_MUL, 1'b1);
        push(SAT ? ALU_SMAX : 0, 1'b1, 1'b1);
        send(65536, 65536, OP_MUL, 1'b1);
        push(-2, 1'b1, 1'b0);
        send(-2, 5, OP_MIN, 1'b1);
        push(5, 1'b1, 1'b0);
        send(-2, 5, OP_MAX, 1'b1);

        // Reductions
        push(60, 1'b1, 1'b0);
        send(10, 0, OP_RSUM, 1'b0);
        check("rsum_quiet1", out_valid, 1'b0);
        send(20, 0, OP_RSUM, 1'b0);
        check("rsum_quiet2", out_valid, 1'b0);
        send(30, 0, OP_RSUM, 1'b1);
        push(-5, 1'b1, 1'b0);
        send(-5, 0, OP_RMAX, 1'b0);
        send(-9, 0, OP_RMAX, 1'b1);
        push(1, 1'b1, 1'b0);
        send(77, 0, OP_RCNT, 1'b1);
        push(-8, 1'b1, 1'b0);
        send(3, 0, OP_RMIN, 1'b0);
        send(-8, 0, OP_RMIN, 1'b0);
        send(4, 0, OP_RMIN, 1'b0);
        send(0, 0, OP_RMIN, 1'b1);
        // RSUM overflowing mid-frame: wrap gives MAX+1-1, clamp holds MAX
        push(ALU_SMAX, 1'b1, 1'b1);
        send(ALU_SMAX, 0, OP_RSUM, 1'b0);
        send(1, 0, OP_RSUM, 1'b0);
        send(-1, 0, OP_RSUM, 1'b1);

        // Backpressure during an ADD stream
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        push(2, 1'b0, 1'b0);
        push(4, 1'b0, 1'b0);
        push(6, 1'b0, 1'b0);
        push(8, 1'b1, 1'b0);
        send(1, 1, OP_ADD, 1'b0);
        fork
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 1'b0);
                    check("bp_hold", out, 2);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        send(2, 2, OP_ADD, 1'b0);
        send(3, 3, OP_ADD, 1'b0);
        send(4, 4, OP_ADD, 1'b1);

        // Opcode change inside an RSUM frame
        repeat (2) @(negedge clk);
        check("err_clear", err, 1'b0);
        push(18, 1'b1, 1'b0);
        send(5, 0, OP_RSUM, 1'b0);
        send(6, 0, OP_SUB, 1'b0);
        check("err_set", err, 1'b1);
        send(7, 0, OP_RSUM, 1'b1);
        check("err_sticky", err, 1'b1);

        // Reset in the middle of an RSUM frame
        repeat (2) @(negedge clk);
        send(100, 0, OP_RSUM, 1'b0);
        send(200, 0, OP_RSUM, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_out", out, 0);
        check("mrst_out_last", out_last, 1'b0);
        check("mrst_ovf", ovf, 1'b0);
        check("mrst_err", err, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        push(2, 1'b1, 1'b0);
        send(1, 0, OP_RSUM, 1'b0);
        send(1, 0, OP_RSUM, 1'b1);

        // Unknown opcode
        push(0, 1'b1, 1'b0);
        send(123, 45, 4'd5, 1'b1);
        check("unknown_err", err, 1'b1);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/column_alu.md
Name: column_alu

Overview:
- Streaming two-operand ALU for column operations.
- Elementwise ops emit one result per input beat. Reduction ops accumulate over a frame delimited by in_last and emit one result per frame.
- Valid/ready handshake on both sides, with one registered output stage.
- Generalises the single-op adder datapath in width, opcode set and mode, and adds backpressure.

Parameters:
- DATA_W, 32, signed operand/result width.
- CMD_W, 4, opcode width; bit CMD_W-1 set means a reduction op.
- CNT_W, 16, width of the RCNT beat counter (CNT_W <= DATA_W).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat.
- in1  in  DATA_W  signed operand A; the reduction operand.
- in2  in  DATA_W  signed operand B; ignored by reductions.
- cmd  in  CMD_W  opcode.
- in_last  in  1  last beat of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out  out  DATA_W  signed result.
- out_last  out  1  result closes a frame.
- ovf  out  1  overflow occurred for this result.
- err  out  1  sticky error flag.

Behaviour:
- Reset (reset_n=0 at clk edge):
  - out_valid=0, out=0, out_last=0, ovf=0, err=0.
  - Accumulator=0, count=0, FSM to S_IDLE.
  - Applies mid-frame too: partial accumulation is discarded and no result is emitted.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - Result consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational pass-through of backpressure).
  - Output holds stable while out_valid && !out_ready.
- Latency: result registered 1 cycle after the accepting edge. Full throughput: 1 beat/cycle when out_ready=1.
- Opcodes (elementwise):
  - OP_ADD=0: in1+in2.
  - OP_SUB=1: in1-in2.
  - OP_MUL=2: low DATA_W bits of in1*in2.
  - OP_MIN=3, OP_MAX=4: signed compare.
- Opcodes (reductions):
  - OP_RSUM=8, OP_RMIN=9, OP_RMAX=10 operate over in1.
  - OP_RCNT=11: number of beats in the frame, zero-extended, saturating at 2^CNT_W-1.
- FSM:
  - S_IDLE: the first accepted beat latches cmd and goes to S_FRAME, unless in_last=1, which keeps S_IDLE.
  - S_FRAME: beats use the latched cmd. The in_last beat returns to S_IDLE.
- Mid-frame opcode change: if cmd differs from the latched cmd, err is set. err is sticky until reset; the latched cmd is still used.
- Elementwise output:
  - out_valid pulses for every accepted beat.
  - out_last mirrors in_last.
- Reduction output:
  - No output on non-last beats; the accumulator updates.
  - The last beat emits op(acc, in1), out_last=1, then clears acc/count.
  - Single-beat frame: RSUM/RMIN/RMAX output in1; RCNT outputs 1.
- Unknown opcode: beat consumed, out=0, err=1, treated as elementwise (one output per beat).
- Overflow:
  - ovf=1 when the exact signed ADD/SUB/MUL/RSUM result is not representable in DATA_W.
  - For RSUM, ovf is set on the final result if any step of the frame overflowed.
  - The default result wraps (two's complement).
- Simultaneous consume and accept in one cycle: the new result replaces the old; no bubble.

Optional Feature:
- Macro ALU_SAT_EN.
- When defined: ADD/SUB/MUL/RSUM saturate to the signed extremes, -2^(DATA_W-1) or 2^(DATA_W-1)-1. RSUM saturates at each step and stays clamped until the frame ends. ovf is still asserted.
- When undefined: wrap-around results; ovf is still asserted.

Decomposition:
- Shared package column_alu_pkg holds:
  - the opcode enum op_e (OP_ADD..OP_RCNT);
  - the FSM state enum (S_IDLE, S_FRAME);
  - the is_reduction(cmd) helper;
  - the signed MIN/MAX constants.
- One natural sub-module, column_alu_arith: combinational op/overflow/saturation unit shared by the elementwise and reduction paths. Inputs: a, b, op. Outputs: result, ovf.

Test Plan:
- ADD beats (5,7), (-3,2), (2^31-1,1) with out_ready=1 -> out 12, -1, -2^31 with ovf=1 (2^31-1 with ALU_SAT_EN); one result per cycle, latency 1.
- RSUM frame in1=10,20,30 (last on 3rd beat) -> single result 60, out_last=1, no out_valid on beats 1-2; a following RMAX frame -5,-9 -> -5.
- RCNT single-beat frame -> out 1, out_last=1; 4-beat RMIN frame 3,-8,4,0 -> -8.
- Backpressure: out_ready=0 for 3 cycles during an ADD stream -> in_ready=0, out holds its value, no beat lost or duplicated after release.
- Opcode change mid-RSUM frame (cmd 8 -> 1) -> err=1 (sticky); RSUM continues to completion.
- reset_n=0 mid-RSUM frame after 2 beats, then a new RSUM frame of 1,1 -> all outputs 0 during reset; the new frame outputs 2 (no stale accumulation).
